q_frag_init_seq: RTL and testbench
==================================

Name: q_frag_init_seq

Overview:
Power-up and re-initialisation sequencer for a bank of N_FRAG Q_FRAG flip-flop fragments. On request it forces each fragment to a per-bit init value through the user set/reset override path (UQST/QSTS, UQRT/QRTS). It then releases the overrides glitch-free and in staggered order, and finally raises the clock-data-enable (CDS) so normal QCK capture resumes. It sits between the fabric configuration/reset controller and the Q_FRAG array.

Parameters:
N_FRAG, 8, number of Q_FRAG fragments controlled (>=1).
HOLD_CYCLES, 4, cycles the set/reset override is held active (>=1).
STAGGER, 1, cycles between successive per-fragment override releases (>=1).

Ports:
QCK  input  1  clock, same net as the fragments' QCK.
QRTN  input  1  asynchronous active-low reset.
start  input  1  request an init sequence; sampled on QCK rise in IDLE only.
abort  input  1  synchronous abort of a running sequence.
init_val  input  N_FRAG  per-fragment target value; latched when start is accepted.
UQST  output  N_FRAG  user set value to fragments.
QSTS  output  N_FRAG  user set select to fragments.
UQRT  output  N_FRAG  user reset value to fragments.
QRTS  output  N_FRAG  user reset select to fragments.
CDS  output  N_FRAG  capture enable to fragments.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse on successful completion.
aborted  output  1  one-cycle pulse when abort is taken.

Behaviour:
- Clock and reset: one clock, QCK. Reset QRTN is asynchronous and active-low. All outputs are registered.
- Reset values while QRTN=0, and immediately on its assertion, including mid-sequence: UQST, QSTS, UQRT, QRTS, CDS, busy, done and aborted are all 0. State goes to IDLE, and the latched init value and counters are cleared.
- States: IDLE, ASSERT, DEASSERT, RELEASE, ENABLE.
- Cycle numbering: cycle n is the n-th cycle after the edge on which start was accepted.
- IDLE:
  - CDS holds its last value: 0 after reset, all-1 after a completed sequence.
  - On start=1: latch init_val into init_q, clear CDS to 0, go to ASSERT.
- ASSERT (cycles 1..HOLD_CYCLES):
  - QSTS and QRTS are all-1.
  - UQST = init_q and UQRT = ~init_q. The reset override therefore wins only where init_q=0.
  - busy=1. A down-counter loaded with HOLD_CYCLES-1 sets the dwell.
- DEASSERT (cycle HOLD_CYCLES+1):
  - UQST and UQRT go all-0 while QSTS and QRTS stay all-1.
  - The select muxes see 0/0, so the fragments keep their forced value and no transient set/reset reaches them.
- RELEASE (cycles HOLD_CYCLES+2 .. HOLD_CYCLES+1+N_FRAG*STAGGER):
  - Index idx runs 0..N_FRAG-1.
  - At the start of step idx, QSTS[idx] and QRTS[idx] clear. Each step lasts STAGGER cycles.
  - Released bits stay 0. Unreleased bits stay 1.
- ENABLE (cycle HOLD_CYCLES+2+N_FRAG*STAGGER):
  - CDS goes all-1 and done=1 for this single cycle.
  - Next cycle: state returns to IDLE, busy=0, CDS stays all-1.
- Total latency from start to done is HOLD_CYCLES+2+N_FRAG*STAGGER cycles.
- start while busy=1 is ignored and not queued. start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- abort=1 in ASSERT, DEASSERT or RELEASE:
  - Next edge: UQST=UQRT=0, QSTS=QRTS=0, CDS=0, aborted=1 for one cycle, busy=0, state IDLE. done is not pulsed.
  - abort in ENABLE is ignored; completion wins.
- init_val changes after acceptance have no effect.
- Counter widths: $clog2(HOLD_CYCLES+1), $clog2(STAGGER+1), $clog2(N_FRAG+1). Counters never wrap; each terminates on its terminal value.
- Invariant, a checked assertion: for every bit, UQST & UQRT == 0. Also, QSTS[i] == QRTS[i] in every cycle.

Decomposition:
- Package q_frag_ctrl_pkg holds:
  - the state enum (IDLE, ASSERT, DEASSERT, RELEASE, ENABLE);
  - width helper functions for the counters.
- One natural sub-module, q_frag_stagger_cnt: a loadable down-counter with terminal-count flag. It is instantiated twice, for the hold counter and the stagger/index pacing.
- The FSM and output registers stay in q_frag_init_seq.

Test Plan:
1. Reset then start, with N_FRAG=8, HOLD_CYCLES=4, STAGGER=1, init_val=8'hA5:
   - cycles 1-4: QSTS=QRTS=FF, UQST=A5, UQRT=5A;
   - cycle 5: UQST=UQRT=00;
   - cycles 6-13: QSTS=QRTS clear bit 0..7, one per cycle;
   - cycle 14: CDS=FF, done=1;
   - behavioural Q_FRAG models then hold A5.
2. STAGGER=3, N_FRAG=4, HOLD_CYCLES=2 -> each select bit clears 3 cycles after the previous one; done arrives at cycle 16.
3. abort at cycle 7 of scenario 1 -> next edge: all selects 0, CDS=00, aborted=1, busy=0, no done pulse.
4. QRTN pulsed low at cycle 3 -> all outputs 0 asynchronously; a new start after release restarts from cycle 1 with a fresh init_val latch.
5. start re-asserted during busy, and init_val changed mid-sequence -> no restart, final CDS timing unchanged, and the forced pattern equals the originally latched value.
6. Random init_val over 200 sequences -> assertion UQST&UQRT==0 never fires; fragment outputs equal the latched init_val at done.

Source files
------------

// File: rtl/q_frag_ctrl_pkg.sv
// Shared types and counter-width helpers for the Q_FRAG init sequencer.
package q_frag_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_DEASSERT,
    ST_RELEASE,
    ST_ENABLE
  } frag_state_e;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/q_frag_stagger_cnt.sv
// Loadable down-counter that parks at zero; tc flags the terminal value.
module q_frag_stagger_cnt #(
  parameter int W = 2
) (
  input  logic         QCK,
  input  logic         QRTN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/q_frag_init_seq.sv
// Forces a bank of Q_FRAG fragments to an init pattern through the set/reset
// override path, releases the overrides one fragment at a time, then enables capture.
//
// state       | meaning
// ST_IDLE     | waiting for start, CDS holds its last value
// ST_ASSERT   | selects all-1, UQST=init, UQRT=~init for HOLD_CYCLES
// ST_DEASSERT | values dropped to 0 while selects stay 1 (no transient)
// ST_RELEASE  | one select bit cleared every STAGGER cycles, LSB first
// ST_ENABLE   | CDS all-1 and done pulse, back to idle next cycle
module q_frag_init_seq
  import q_frag_ctrl_pkg::*;
#(
  parameter int N_FRAG      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 1
) (
  input  logic              QCK,
  input  logic              QRTN,
  input  logic              start,
  input  logic              abort,
  input  logic [N_FRAG-1:0] init_val,
  output logic [N_FRAG-1:0] UQST,
  output logic [N_FRAG-1:0] QSTS,
  output logic [N_FRAG-1:0] UQRT,
  output logic [N_FRAG-1:0] QRTS,
  output logic [N_FRAG-1:0] CDS,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int SW = cnt_w(STAGGER);
  localparam int IW = cnt_w(N_FRAG);
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]     STAG_LOAD = SW'(STAGGER - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(N_FRAG - 1);
  localparam logic [N_FRAG-1:0] BIT0      = N_FRAG'(1);

  frag_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_FRAG-1:0] init_q, init_d;
  logic [N_FRAG-1:0] uqst_q, uqst_d;
  logic [N_FRAG-1:0] uqrt_q, uqrt_d;
  logic [N_FRAG-1:0] sel_q, sel_d;
  logic [N_FRAG-1:0] cds_q, cds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic hold_load, hold_en, hold_tc;
  logic stag_load, stag_en, stag_tc;
  logic abort_acc;

  assign abort_acc = abort && ((state_q == ST_ASSERT) || (state_q == ST_DEASSERT) ||
                               (state_q == ST_RELEASE));
  assign hold_en   = (state_q == ST_ASSERT);
  assign stag_en   = (state_q == ST_RELEASE);

  q_frag_stagger_cnt #(.W(HW)) u_hold_cnt (
    .QCK      (QCK),
    .QRTN     (QRTN),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (hold_en),
    .tc       (hold_tc)
  );

  q_frag_stagger_cnt #(.W(SW)) u_stag_cnt (
    .QCK      (QCK),
    .QRTN     (QRTN),
    .load     (stag_load),
    .load_val (STAG_LOAD),
    .en       (stag_en),
    .tc       (stag_tc)
  );

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      init_q    <= '0;
      uqst_q    <= '0;
      uqrt_q    <= '0;
      sel_q     <= '0;
      cds_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      init_q    <= init_d;
      uqst_q    <= uqst_d;
      uqrt_q    <= uqrt_d;
      sel_q     <= sel_d;
      cds_q     <= cds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    init_d    = init_q;
    hold_load = 1'b0;
    stag_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ASSERT;
          init_d    = init_val;
          hold_load = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold_tc) begin
          state_d = ST_DEASSERT;
        end
      end
      ST_DEASSERT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_RELEASE;
          idx_d     = '0;
          stag_load = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (stag_tc) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_ENABLE;
          end else begin
            idx_d     = idx_q + 1'b1;
            stag_load = 1'b1;
          end
        end
      end
      ST_ENABLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uqst_d    = uqst_q;
    uqrt_d    = uqrt_q;
    sel_d     = sel_q;
    cds_d     = cds_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (abort_acc) begin
      uqst_d    = '0;
      uqrt_d    = '0;
      sel_d     = '0;
      cds_d     = '0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            uqst_d = init_val;
            uqrt_d = ~init_val;
            sel_d  = '1;
            cds_d  = '0;
            busy_d = 1'b1;
          end
        end
        ST_ASSERT: begin
          if (state_d == ST_DEASSERT) begin
            uqst_d = '0;
            uqrt_d = '0;
          end else begin
            uqst_d = init_q;
            uqrt_d = ~init_q;
          end
        end
        ST_DEASSERT, ST_RELEASE: begin
          if (state_d == ST_ENABLE) begin
            cds_d  = '1;
            done_d = 1'b1;
          end else if (stag_load) begin
            sel_d = sel_q & ~(BIT0 << idx_d);
          end
        end
        ST_ENABLE: busy_d = 1'b0;
        default:   busy_d = 1'b0;
      endcase
    end
  end

  assign UQST    = uqst_q;
  assign UQRT    = uqrt_q;
  assign QSTS    = sel_q;
  assign QRTS    = sel_q;
  assign CDS     = cds_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

  // Set and reset values must never both be high, and the two selects move together.
  a_override_excl: assert property (@(posedge QCK) disable iff (!QRTN)
    ((UQST & UQRT) == '0) && (QSTS == QRTS));

endmodule

// File: tb/tb_q_frag_init_seq.sv
// Randomized self-checking bench for q_frag_init_seq against a cycle-number based model.
module tb_q_frag_init_seq;

  logic QCK;
  logic QRTN;

  logic       a_start, a_abort;
  logic [7:0] a_init, a_uqst, a_qsts, a_uqrt, a_qrts, a_cds;
  logic       a_busy, a_done, a_aborted;

  logic       b_start, b_abort;
  logic [3:0] b_init, b_uqst, b_qsts, b_uqrt, b_qrts, b_cds;
  logic       b_busy, b_done, b_aborted;

  logic [7:0] o_uqst, o_qsts, o_uqrt, o_qrts, o_cds;
  logic       o_busy, o_done, o_aborted;
  logic [42:0] obs;

  int cur;
  int n_vec;
  int n_miss;

  q_frag_init_seq #(.N_FRAG(8), .HOLD_CYCLES(4), .STAGGER(1)) u_dut_a (
    .QCK(QCK), .QRTN(QRTN), .start(a_start), .abort(a_abort), .init_val(a_init),
    .UQST(a_uqst), .QSTS(a_qsts), .UQRT(a_uqrt), .QRTS(a_qrts), .CDS(a_cds),
    .busy(a_busy), .done(a_done), .aborted(a_aborted)
  );

  q_frag_init_seq #(.N_FRAG(4), .HOLD_CYCLES(2), .STAGGER(3)) u_dut_b (
    .QCK(QCK), .QRTN(QRTN), .start(b_start), .abort(b_abort), .init_val(b_init),
    .UQST(b_uqst), .QSTS(b_qsts), .UQRT(b_uqrt), .QRTS(b_qrts), .CDS(b_cds),
    .busy(b_busy), .done(b_done), .aborted(b_aborted)
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  always_comb begin
    if (cur == 0) begin
      o_uqst = a_uqst; o_qsts = a_qsts; o_uqrt = a_uqrt; o_qrts = a_qrts; o_cds = a_cds;
      o_busy = a_busy; o_done = a_done; o_aborted = a_aborted;
    end else begin
      o_uqst = {4'b0, b_uqst}; o_qsts = {4'b0, b_qsts}; o_uqrt = {4'b0, b_uqrt};
      o_qrts = {4'b0, b_qrts}; o_cds = {4'b0, b_cds};
      o_busy = b_busy; o_done = b_done; o_aborted = b_aborted;
    end
    obs = {o_busy, o_done, o_aborted, o_cds, o_qrts, o_uqrt, o_qsts, o_uqst};
  end

  task automatic check_val(input string tag, input logic [42:0] got, input logic [42:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", tag, cur, $time, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic st, input logic [7:0] iv, input logic ab);
    if (which == 0) begin
      a_start = st; a_init = iv; a_abort = ab;
    end else begin
      b_start = st; b_init = iv[3:0]; b_abort = ab;
    end
  endtask

  // Expected outputs at cycle t after the accepting edge, straight from the timeline rules.
  function automatic logic [42:0] exp_vec(input int n, input int h, input int s,
                                          input logic [7:0] init, input int t);
    logic [7:0] all, sel, uq, ur, cds;
    logic       bsy, dn;
    int         k;
    all = 8'hFF >> (8 - n);
    sel = 8'h00; uq = 8'h00; ur = 8'h00; cds = 8'h00; bsy = 1'b1; dn = 1'b0;
    if (t <= h) begin
      sel = all; uq = init & all; ur = ~init & all;
    end else if (t == h + 1) begin
      sel = all;
    end else if (t <= h + 1 + n * s) begin
      k = (t - h - 2) / s;
      sel = (all << (k + 1)) & all;
    end else if (t == h + 2 + n * s) begin
      cds = all; dn = 1'b1;
    end else begin
      cds = all; bsy = 1'b0;
    end
    return {bsy, dn, 1'b0, cds, sel, ur, sel, uq};
  endfunction

  task automatic run_seq(input int which, input logic [7:0] init, input int abort_at,
                         input int reset_at, input bit chaos);
    int n, h, s, t_done;
    logic [7:0] all, frag, d, iv;
    logic st, ab;
    cur = which;
    n = (which == 0) ? 8 : 4;
    h = (which == 0) ? 4 : 2;
    s = (which == 0) ? 1 : 3;
    t_done = h + 2 + n * s;
    all = 8'hFF >> (8 - n);
    frag = 8'($urandom);
    drive(which, 1'b1, init, chaos ? 1'($urandom) : 1'b0);
    for (int t = 1; t <= t_done + 1; t++) begin
      @(posedge QCK);
      #1;
      if (abort_at != 0 && t == abort_at + 1) begin
        check_val("abort_taken", obs, {3'b001, 40'b0});
        drive(which, 1'b0, init, 1'b0);
        @(posedge QCK);
        #1;
        check_val("post_abort_idle", obs, 43'b0);
        return;
      end
      check_val("seq", obs, exp_vec(n, h, s, init, t));
      check_val("set_rst_excl", {35'b0, o_uqst & o_uqrt}, 43'b0);
      if (t == t_done) check_val("frag_forced", {35'b0, frag & all}, {35'b0, init & all});
      if (t == reset_at) begin
        QRTN = 1'b0;
        #2;
        check_val("async_reset", obs, 43'b0);
        drive(which, 1'b0, init, 1'b0);
        @(posedge QCK);
        #1;
        check_val("held_reset", obs, 43'b0);
        QRTN = 1'b1;
        return;
      end
      d = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        if (o_qsts[i] && o_uqst[i]) frag[i] = 1'b1;
        else if (o_qrts[i] && o_uqrt[i]) frag[i] = 1'b0;
        else if (o_cds[i]) frag[i] = d[i];
      end
      st = chaos ? 1'($urandom) : 1'b0;
      iv = chaos ? 8'($urandom) : init;
      ab = (t == abort_at) || (chaos && t == t_done && 1'($urandom));
      drive(which, st, iv, ab);
    end
    drive(which, 1'b0, init, 1'b0);
  endtask

  initial begin
    int which, ab_at, tdone;
    n_vec = 0;
    n_miss = 0;
    cur = 0;
    QRTN = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge QCK);
    #1;
    check_val("reset_a", obs, 43'b0);
    cur = 1;
    #1;
    check_val("reset_b", obs, 43'b0);
    QRTN = 1'b1;
    @(posedge QCK);
    #1;

    run_seq(0, 8'hA5, 0, 0, 1'b0);
    run_seq(1, 8'h06, 0, 0, 1'b0);
    run_seq(0, 8'h3C, 7, 0, 1'b0);
    run_seq(0, 8'h81, 0, 3, 1'b0);
    run_seq(0, 8'h5E, 0, 0, 1'b0);
    run_seq(0, 8'hC3, 0, 0, 1'b1);
    run_seq(1, 8'h09, 0, 0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      which = (i % 4 == 3) ? 1 : 0;
      tdone = (which == 0) ? 14 : 16;
      ab_at = (i % 5 == 2) ? int'($urandom_range(tdone - 1, 1)) : 0;
      run_seq(which, 8'($urandom), ab_at, 0, 1'(i % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
